// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences multi-cycle HI/LO ops (MADD/MADDU/MSUB/MSUBU via an external product, DIV/DIVU via an external divider)
// Ports: clk/rst (sync, active-high); op_valid_i/op_i/opdata*_i accept an op from EX;
// mul_res_i product; hi_i/lo_i forwarded HI/LO; flush_i annuls the in-flight op;
// div_* handshake with the divider; stallreq_o holds the pipeline; whilo_o/hi_o/lo_o/done_o write HI/LO.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic [63:0] mul_res_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o
);
    typedef enum logic [1:0] {IDLE, ACC, DIV_WAIT, DIV_DONE} state_t;
    state_t      r_state, w_next;
    logic [63:0] r_acc, r_res, w_acc_n, w_res_n, w_hilo;
    logic [31:0] r_op1, r_op2;
    logic [2:0]  r_op;
    logic        w_accept, w_is_div, w_is_sub;
    logic        w_start, w_annul, w_signed, w_stall, w_whilo;
    logic [31:0] w_op1, w_op2;
    assign w_accept = r_state == IDLE && op_valid_i && op_i != 3'd0 && op_i != 3'd7 && !flush_i;
    assign w_is_div = op_i == 3'd5 || op_i == 3'd6;
    assign w_is_sub = op_i == 3'd3 || op_i == 3'd4;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_res   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc_n;
            r_res   <= w_res_n;
            if (w_accept) begin
                r_op1 <= opdata1_i;
                r_op2 <= opdata2_i;
                r_op  <= op_i;
            end
        end
    end
    always_comb begin
        w_next   = r_state;
        w_acc_n  = r_acc;
        w_res_n  = r_res;
        w_start  = 1'b0;
        w_annul  = 1'b0;
        w_signed = 1'b0;
        w_stall  = 1'b0;
        w_whilo  = 1'b0;
        w_op1    = '0;
        w_op2    = '0;
        w_hilo   = '0;
        case (r_state)
            IDLE: begin
                w_stall = w_accept;
                if (w_accept && !w_is_div) begin
                    w_next  = ACC;
                    w_acc_n = w_is_sub ? ~mul_res_i + 64'd1 : mul_res_i;
                end else if (w_accept) begin
                    w_next  = opdata2_i == '0 ? DIV_DONE : DIV_WAIT;
                    w_res_n = '0;
                end
            end
            ACC: begin
                w_next  = IDLE;
                w_whilo = !flush_i;
                w_hilo  = flush_i ? '0 : r_acc + {hi_i, lo_i};
            end
            DIV_WAIT: begin
                w_stall  = 1'b1;
                w_op1    = r_op1;
                w_op2    = r_op2;
                w_signed = r_op == 3'd5;
                w_annul  = flush_i;
                w_start  = !flush_i;
                // flush wins over a simultaneous div_ready_i
                if (flush_i)
                    w_next = IDLE;
                else if (div_ready_i) begin
                    w_next  = DIV_DONE;
                    w_res_n = div_result_i;
                end
            end
            default: begin
                w_next  = IDLE;
                w_whilo = !flush_i;
                w_hilo  = flush_i ? '0 : r_res;
            end
        endcase
    end
    // outputs are held quiet for the whole reset cycle so an abandoned op never writes or annuls
    always_comb begin
        div_start_o  = !rst && w_start;
        div_annul_o  = !rst && w_annul;
        div_signed_o = !rst && w_signed;
        div_op1_o    = rst ? '0 : w_op1;
        div_op2_o    = rst ? '0 : w_op2;
        stallreq_o   = !rst && w_stall;
        whilo_o      = !rst && w_whilo;
        done_o       = !rst && w_whilo;
        {hi_o, lo_o} = rst ? '0 : w_hilo;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq; expected HI/LO writes are queued at accept and popped on done_o
module tb_muldiv_seq;
    logic        clk, rst, op_valid, flush, rdy;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] mul, dres;
    logic        div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o, done_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
    logic [63:0] q[$];
    int          n_pass, n_chk;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op),
        .opdata1_i(a), .opdata2_i(b), .mul_res_i(mul), .hi_i(hi), .lo_i(lo),
        .flush_i(flush), .div_ready_i(rdy), .div_result_i(dres),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .stallreq_o(stallreq_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic clr;
        op_valid = 1'b0; op = 3'd0; flush = 1'b0; rdy = 1'b0;
        a = '0; b = '0; mul = '0; dres = '0;
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_ctl"}, {div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o, done_o}, 64'd0);
        check({tag, "_dop"}, {div_op1_o, div_op2_o}, 64'd0);
        check({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
    endtask

    always @(negedge clk) begin
        #2;
        check("done_eq_whilo", done_o, whilo_o);
        if (!whilo_o) check("hilo_idle_zero", {hi_o, lo_o}, 64'd0);
        if (done_o) begin
            check("wr_expected", q.size(), (q.size() > 0) ? q.size() : 1);
            if (q.size() > 0) check("hilo", {hi_o, lo_o}, q.pop_front());
        end
    end

    initial begin
        n_pass = 0; n_chk = 0;
        clr; rst = 1'b1; hi = '0; lo = '0;
        for (int i = 0; i < 3; i++) begin
            nxt; op_valid = 1'b1; op = 3'd1; mul = 64'd4; #1;
            chk_quiet("rst");
        end
        nxt; rst = 1'b0; clr; #1;
        chk_quiet("post_rst");

        nxt; op_valid = 1'b1; op = 3'd1; hi = 0; lo = 5; mul = 64'd12; #1;
        check("madd_stall", stallreq_o, 1); q.push_back(64'd17);
        nxt; clr; #1;
        check("madd_whilo", whilo_o, 1); check("madd_stall_acc", stallreq_o, 0);

        nxt; op_valid = 1'b1; op = 3'd3; hi = 0; lo = 3; mul = 64'd10; #1;
        check("msub_stall", stallreq_o, 1); q.push_back(64'hFFFFFFFF_FFFFFFF9);
        nxt; clr; #1;
        check("msub_whilo", whilo_o, 1);

        for (int i = 0; i < 4; i++) begin
            nxt; op_valid = 1'b1; op = 3'd2; hi = 32'd1; lo = 32'hFFFFFFFF; mul = 64'd1; #1;
            check("b2b_done", done_o, (i % 2 == 1));
            check("b2b_stall", stallreq_o, (i % 2 == 0));
            if (i % 2 == 0) q.push_back(64'h2_00000000);
        end

        nxt; clr; op_valid = 1'b1; op = 3'd4; hi = 0; lo = 0; mul = 64'h1_00000000; #1;
        q.push_back(64'hFFFFFFFF_00000000);
        nxt; clr; #1;
        check("msubu_whilo", whilo_o, 1);

        nxt; op_valid = 1'b1; op = 3'd6; a = 32'd100; b = 32'd7; #1;
        check("divu_acc_stall", stallreq_o, 1); check("divu_acc_start", div_start_o, 0);
        for (int i = 0; i < 5; i++) begin
            nxt; clr; op_valid = 1'b1; op = 3'd1; rdy = (i == 4); dres = {32'd2, 32'd14}; #1;
            check("divu_start", div_start_o, 1); check("divu_stall", stallreq_o, 1);
            check("divu_ops", {div_op1_o, div_op2_o}, {32'd100, 32'd7});
            check("divu_signed", div_signed_o, 0);
            if (i == 4) q.push_back({32'd2, 32'd14});
        end
        nxt; clr; #1;
        check("divu_done_whilo", whilo_o, 1); check("divu_done_stall", stallreq_o, 0);
        check("divu_done_start", div_start_o, 0); check("divu_done_ops", {div_op1_o, div_op2_o}, 64'd0);
        nxt; rdy = 1'b1; dres = 64'hDEAD; #1;
        check("rdy_idle_stall", stallreq_o, 0);
        nxt; clr; #1;
        check("rdy_idle_whilo", whilo_o, 0);

        nxt; op_valid = 1'b1; op = 3'd5; a = 32'hFFFFFFEC; b = 32'd3; #1;
        nxt; clr; rdy = 1'b1; dres = {32'hFFFFFFFE, 32'hFFFFFFFA}; #1;
        check("div_signed", div_signed_o, 1); q.push_back({32'hFFFFFFFE, 32'hFFFFFFFA});
        nxt; clr; #1;
        check("div_whilo", whilo_o, 1);

        nxt; op_valid = 1'b1; op = 3'd5; a = 32'd9; b = 32'd0; #1;
        check("div0_stall", stallreq_o, 1); check("div0_start0", div_start_o, 0); q.push_back(64'd0);
        nxt; clr; #1;
        check("div0_start1", div_start_o, 0); check("div0_whilo", whilo_o, 1);

        nxt; op_valid = 1'b1; op = 3'd6; a = 32'd50; b = 32'd5; #1;
        nxt; clr; flush = 1'b1; rdy = 1'b1; dres = 64'h55; #1;
        check("fl_annul", div_annul_o, 1); check("fl_start", div_start_o, 0); check("fl_whilo", whilo_o, 0);
        nxt; clr; op_valid = 1'b1; op = 3'd1; hi = 0; lo = 1; mul = 64'd2; #1;
        check("fl_annul_off", div_annul_o, 0); check("fl_madd_stall", stallreq_o, 1); q.push_back(64'd3);
        nxt; clr; #1;
        check("fl_madd_whilo", whilo_o, 1);

        nxt; op_valid = 1'b1; op = 3'd1; flush = 1'b1; #1;
        check("fl_idle_stall", stallreq_o, 0);
        nxt; clr; #1;
        check("fl_idle_whilo", whilo_o, 0);
        nxt; op_valid = 1'b1; op = 3'd0; #1;
        check("nop0_stall", stallreq_o, 0);
        nxt; op = 3'd7; #1;
        check("nop7_stall", stallreq_o, 0); check("nop0_whilo", whilo_o, 0);
        nxt; clr; #1;
        check("nop7_whilo", whilo_o, 0);

        nxt; op_valid = 1'b1; op = 3'd1; mul = 64'd9; #1;
        nxt; clr; flush = 1'b1; #1;
        check("fl_acc_whilo", whilo_o, 0); check("fl_acc_done", done_o, 0);
        nxt; clr; op_valid = 1'b1; op = 3'd1; hi = 32'd7; lo = 32'd8; mul = 64'd1; #1;
        check("fl_acc_next_stall", stallreq_o, 1); q.push_back({32'd7, 32'd9});
        nxt; clr; #1;
        check("fl_acc_next_whilo", whilo_o, 1);

        nxt; op_valid = 1'b1; op = 3'd5; b = 32'd0; #1;
        nxt; clr; flush = 1'b1; #1;
        check("fl_done_whilo", whilo_o, 0);
        nxt; clr; #1;
        check("fl_done_idle", {stallreq_o, whilo_o}, 0);

        nxt; op_valid = 1'b1; op = 3'd1; mul = 64'd100; #1;
        nxt; clr; rst = 1'b1; #1;
        chk_quiet("rst_acc");
        nxt; rst = 1'b0; #1;
        chk_quiet("rst_acc_after");
        nxt; op_valid = 1'b1; op = 3'd1; hi = 0; lo = 0; mul = 64'd42; #1;
        check("rst_acc_next_stall", stallreq_o, 1); q.push_back(64'd42);
        nxt; clr; #1;
        check("rst_acc_next_whilo", whilo_o, 1);

        nxt; nxt;
        check("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
